// File: rtl/morse_pkg.sv
// Shared Morse definitions: unit timing, FSM encoding, ASCII anchors and the
// encoder output record used by the transmit keyer (and reusable by receive).
package morse_pkg;

    localparam int UNITS_DOT        = 1;
    localparam int UNITS_DASH       = 3;
    localparam int UNITS_ELEM_GAP   = 1;
    localparam int UNITS_CHAR_GAP   = 3;
    localparam int UNITS_WORD_EXTRA = 4;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_Z     = 8'h5A;
    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MARK      = 3'd1,
        ST_ELEM_GAP  = 3'd2,
        ST_CHAR_GAP  = 3'd3,
        ST_WORD_GAP  = 3'd4
    } state_t;

    // pat is MSB-first within len bits, 1 = dash.
    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] len;
        logic [4:0] pat;
    } enc_t;

    function automatic enc_t sym(input logic [2:0] l, input logic [4:0] p);
        return '{valid: 1'b1, is_space: 1'b0, len: l, pat: p};
    endfunction

endpackage

// File: rtl/tx_cw_keyer_if.sv
// Character input handshake for the CW keyer.
// A character transfers on a rising clk edge where char_valid and char_ready
// are both high; char_in must be stable then, and is ignored at all other times.
interface tx_cw_keyer_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_in, output char_valid, input  char_ready);
    modport slave  (input  char_in, input  char_valid, output char_ready);
endinterface

// File: rtl/morse_enc_rom.sv
// Combinational ASCII to Morse encoder: 26 letters (case-folded), 10 digits
// and space; anything else comes back with valid = 0.
module morse_enc_rom
    import morse_pkg::*;
(
    input  logic [7:0] chr,
    output enc_t       enc
);

    logic [7:0] up;

    always_comb begin
        up = chr;
        if ((chr >= (CH_A | 8'h20)) && (chr <= (CH_Z | 8'h20))) begin
            up = chr - 8'h20;
        end
        enc = '0;
        case (up)
            CH_SPACE: enc = '{valid: 1'b1, is_space: 1'b1, len: 3'd0, pat: 5'b0};
            "A": enc = sym(3'd2, 5'b00001);
            "B": enc = sym(3'd4, 5'b01000);
            "C": enc = sym(3'd4, 5'b01010);
            "D": enc = sym(3'd3, 5'b00100);
            "E": enc = sym(3'd1, 5'b00000);
            "F": enc = sym(3'd4, 5'b00010);
            "G": enc = sym(3'd3, 5'b00110);
            "H": enc = sym(3'd4, 5'b00000);
            "I": enc = sym(3'd2, 5'b00000);
            "J": enc = sym(3'd4, 5'b00111);
            "K": enc = sym(3'd3, 5'b00101);
            "L": enc = sym(3'd4, 5'b00100);
            "M": enc = sym(3'd2, 5'b00011);
            "N": enc = sym(3'd2, 5'b00010);
            "O": enc = sym(3'd3, 5'b00111);
            "P": enc = sym(3'd4, 5'b00110);
            "Q": enc = sym(3'd4, 5'b01101);
            "R": enc = sym(3'd3, 5'b00010);
            "S": enc = sym(3'd3, 5'b00000);
            "T": enc = sym(3'd1, 5'b00001);
            "U": enc = sym(3'd3, 5'b00001);
            "V": enc = sym(3'd4, 5'b00001);
            "W": enc = sym(3'd3, 5'b00011);
            "X": enc = sym(3'd4, 5'b01001);
            "Y": enc = sym(3'd4, 5'b01011);
            "Z": enc = sym(3'd4, 5'b01100);
            "0": enc = sym(3'd5, 5'b11111);
            "1": enc = sym(3'd5, 5'b01111);
            "2": enc = sym(3'd5, 5'b00111);
            "3": enc = sym(3'd5, 5'b00011);
            "4": enc = sym(3'd5, 5'b00001);
            "5": enc = sym(3'd5, 5'b00000);
            "6": enc = sym(3'd5, 5'b10000);
            "7": enc = sym(3'd5, 5'b11000);
            "8": enc = sym(3'd5, 5'b11100);
            "9": enc = sym(3'd5, 5'b11110);
            default: enc = '0;
        endcase
    end

endmodule

// File: rtl/tx_cw_keyer.sv
// Morse transmit keyer: takes one ASCII character per handshake and keys
// tx_cw with dot/dash/gap unit timing; unsupported characters are dropped.
module tx_cw_keyer
    import morse_pkg::*;
#(
    parameter int DOT_TICKS = 4,
    parameter int MAX_ELEMS = 5
) (
    input  logic                clk,
    input  logic                rst,
    tx_cw_keyer_if.slave        chr,
    output logic                tx_cw,
    output logic                busy,
    output logic                unsup,
    output state_t              state_dbg
);

    localparam int PW = (DOT_TICKS > 2) ? $clog2(DOT_TICKS) : 1;
    localparam int RW = $clog2(MAX_ELEMS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DOT_TICKS - 1);
    localparam logic [2:0] U_DOT   = 3'(UNITS_DOT);
    localparam logic [2:0] U_DASH  = 3'(UNITS_DASH);
    localparam logic [2:0] U_EGAP  = 3'(UNITS_ELEM_GAP);
    localparam logic [2:0] U_CGAP  = 3'(UNITS_CHAR_GAP);
    localparam logic [2:0] U_WGAP  = 3'(UNITS_WORD_EXTRA);

    state_t               state_q, state_d;
    logic [PW-1:0]        presc_q;
    logic [2:0]           unit_q;
    logic [RW-1:0]        rem_q;
    logic [MAX_ELEMS-1:0] pat_q;
    logic                 tx_cw_q;
    logic                 unsup_q;
    logic                 accept;
    logic                 unit_done;
    logic [2:0]           target;
    enc_t                 enc;

    morse_enc_rom u_rom (
        .chr (chr.char_in),
        .enc (enc)
    );

    assign chr.char_ready = (state_q == ST_IDLE);
    assign busy           = ~chr.char_ready;
    assign accept         = chr.char_valid & chr.char_ready;
    assign tx_cw          = tx_cw_q;
    assign unsup          = unsup_q;
    assign state_dbg      = state_q;

    // pat_q is kept left-aligned so the current element is always the MSB.
    always_comb begin
        target = 3'd0;
        case (state_q)
            ST_MARK:     target = pat_q[MAX_ELEMS-1] ? U_DASH : U_DOT;
            ST_ELEM_GAP: target = U_EGAP;
            ST_CHAR_GAP: target = U_CGAP;
            ST_WORD_GAP: target = U_WGAP;
            default:     target = 3'd0;
        endcase
        unit_done = (state_q != ST_IDLE) && (presc_q == PRESC_LAST)
                    && (unit_q == target - 3'd1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && enc.valid) begin
                    state_d = enc.is_space ? ST_WORD_GAP : ST_MARK;
                end
            end
            ST_MARK: begin
                if (unit_done) begin
                    state_d = (rem_q == RW'(1)) ? ST_CHAR_GAP : ST_ELEM_GAP;
                end
            end
            ST_ELEM_GAP: if (unit_done) state_d = ST_MARK;
            ST_CHAR_GAP: if (unit_done) state_d = ST_IDLE;
            ST_WORD_GAP: if (unit_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            unit_q  <= '0;
            rem_q   <= '0;
            pat_q   <= '0;
            tx_cw_q <= 1'b0;
            unsup_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_cw_q <= (state_d == ST_MARK);
            unsup_q <= accept & ~enc.valid;

            if (state_d != state_q) begin
                presc_q <= '0;
                unit_q  <= '0;
            end else if (state_q != ST_IDLE) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q <= '0;
                    unit_q  <= unit_q + 3'd1;
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end

            if (accept && enc.valid && !enc.is_space) begin
                rem_q <= RW'(enc.len);
                pat_q <= MAX_ELEMS'(enc.pat) << (RW'(MAX_ELEMS) - RW'(enc.len));
            end else if (state_q == ST_MARK && state_d != ST_MARK) begin
                rem_q <= rem_q - RW'(1);
                pat_q <= pat_q << 1;
            end
        end
    end

endmodule
